// File: rtl/tron_mem_pkg.sv
// Shared definitions for the SRAM region streamer.
//   state_t      : transfer FSM states
//   FRAME_*      : default frame-buffer layout (regions 0..FRAME_REGIONS-1)
//   SPRITE_STRIDE: default spacing of the sprite slots after the frame buffers
//   region_base(): word base address of a region (32-bit; callers truncate)
package tron_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ACC,
    RD_OUT,
    WR_WAIT,
    WR_ACC,
    DONE
  } state_t;

  localparam int unsigned NUM_REGIONS   = 10;
  localparam int unsigned FRAME_REGIONS = 2;
  localparam logic [19:0] FRAME_STRIDE  = 20'h4B000;
  localparam logic [19:0] SPRITE_STRIDE = 20'h00400;

  // Frame buffers sit back to back from address 0; sprite slots follow the
  // last frame buffer.
  function automatic logic [31:0] region_base(
    input logic [3:0]  r,
    input int unsigned frame_regions = FRAME_REGIONS,
    input logic [31:0] frame_stride  = 32'(FRAME_STRIDE),
    input logic [31:0] sprite_stride = 32'(SPRITE_STRIDE)
  );
    logic [31:0] ri;
    ri = 32'(r);
    if (ri < frame_regions)
      return ri * frame_stride;
    return frame_regions * frame_stride + (ri - frame_regions) * sprite_stride;
  endfunction

endpackage

// File: rtl/sram_region_base.sv
// Combinational region decoder: region index -> SRAM word base address.
//   region : region index
//   base   : base word address, truncated to ADDR_W bits
//   valid  : region index is below NUM_REGIONS
module sram_region_base
  import tron_mem_pkg::*;
#(
  parameter int unsigned       ADDR_W        = 20,
  parameter int unsigned       NUM_REGIONS   = tron_mem_pkg::NUM_REGIONS,
  parameter int unsigned       FRAME_REGIONS = tron_mem_pkg::FRAME_REGIONS,
  parameter logic [ADDR_W-1:0] FRAME_STRIDE  = ADDR_W'(tron_mem_pkg::FRAME_STRIDE),
  parameter logic [ADDR_W-1:0] SPRITE_STRIDE = ADDR_W'(tron_mem_pkg::SPRITE_STRIDE)
) (
  input  logic [3:0]        region,
  output logic [ADDR_W-1:0] base,
  output logic              valid
);

  always_comb begin
    base  = ADDR_W'(region_base(region, FRAME_REGIONS,
                                32'(FRAME_STRIDE), 32'(SPRITE_STRIDE)));
    valid = (32'(region) < NUM_REGIONS);
  end

endmodule

// File: rtl/sram_region_streamer.sv
// Sequential SRAM bridge: moves `length` consecutive 16-bit words of one
// region between the board SRAM and a valid/ready stream.
//   Clk, Reset            : clock, asynchronous active-high reset
//   start/mode/region/length/abort : transfer request (mode 0 = read, 1 = write)
//   busy, done, err       : status (done/err are single-cycle pulses)
//   rd_data/rd_valid/rd_ready : read stream out
//   wr_data/wr_valid/wr_ready : write stream in
//   SRAM_ADDR, sram_dq_*, CE_N/OE_N/WE_N/UB_N/LB_N : SRAM pins
module sram_region_streamer
  import tron_mem_pkg::*;
#(
  parameter int unsigned       ADDR_W        = 20,
  parameter int unsigned       DATA_W        = 16,
  parameter int unsigned       NUM_REGIONS   = tron_mem_pkg::NUM_REGIONS,
  parameter int unsigned       FRAME_REGIONS = tron_mem_pkg::FRAME_REGIONS,
  parameter logic [ADDR_W-1:0] FRAME_STRIDE  = ADDR_W'(tron_mem_pkg::FRAME_STRIDE),
  parameter logic [ADDR_W-1:0] SPRITE_STRIDE = ADDR_W'(tron_mem_pkg::SPRITE_STRIDE),
  parameter int unsigned       WAIT_STATES   = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic              mode,
  input  logic [3:0]        region,
  input  logic [ADDR_W-1:0] length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  output logic              CE_N,
  output logic              OE_N,
  output logic              WE_N,
  output logic              UB_N,
  output logic              LB_N
);

  // Access-cycle counter: reads use WAIT_STATES+1 cycles, writes one more
  // for data hold after WE_N rises.
  localparam int unsigned    WC_W    = $clog2(WAIT_STATES + 2);
  localparam logic [WC_W-1:0] RD_LAST = WC_W'(WAIT_STATES);
  localparam logic [WC_W-1:0] WR_LAST = WC_W'(WAIT_STATES + 1);

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr, cnt, base;
  logic [WC_W-1:0]   wc;
  logic              region_ok;
  logic              load, step, wc_inc, cap_rd, cap_wr, err_set;

  sram_region_base #(
    .ADDR_W        (ADDR_W),
    .NUM_REGIONS   (NUM_REGIONS),
    .FRAME_REGIONS (FRAME_REGIONS),
    .FRAME_STRIDE  (FRAME_STRIDE),
    .SPRITE_STRIDE (SPRITE_STRIDE)
  ) u_base (
    .region (region),
    .base   (base),
    .valid  (region_ok)
  );

  assign SRAM_ADDR = addr;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d    = state;
    load       = 1'b0;
    step       = 1'b0;
    wc_inc     = 1'b0;
    cap_rd     = 1'b0;
    cap_wr     = 1'b0;
    err_set    = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    rd_valid   = 1'b0;
    wr_ready   = 1'b0;
    sram_dq_oe = 1'b0;
    CE_N       = 1'b1;
    OE_N       = 1'b1;
    WE_N       = 1'b1;
    UB_N       = 1'b1;
    LB_N       = 1'b1;

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (!region_ok) begin
            err_set = 1'b1;
          end else if (length == '0) begin
            state_d = DONE;
          end else begin
            load    = 1'b1;
            state_d = mode ? WR_WAIT : RD_ACC;
          end
        end
      end
      RD_ACC: begin
        CE_N = 1'b0;
        OE_N = 1'b0;
        UB_N = 1'b0;
        LB_N = 1'b0;
        if (wc == RD_LAST) begin
          cap_rd  = 1'b1;
          state_d = RD_OUT;
        end else begin
          wc_inc = 1'b1;
        end
      end
      RD_OUT: begin
        rd_valid = 1'b1;
        if (rd_ready) begin
          step    = 1'b1;
          state_d = (cnt == ADDR_W'(1)) ? DONE : RD_ACC;
        end
      end
      WR_WAIT: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          cap_wr  = 1'b1;
          state_d = WR_ACC;
        end
      end
      WR_ACC: begin
        sram_dq_oe = 1'b1;
        CE_N       = 1'b0;
        UB_N       = 1'b0;
        LB_N       = 1'b0;
        WE_N       = (wc == WR_LAST);
        if (wc == WR_LAST) begin
          step    = 1'b1;
          state_d = (cnt == ADDR_W'(1)) ? DONE : WR_WAIT;
        end else begin
          wc_inc = 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything, including a handshake in the same cycle.
    if (state != IDLE && abort) begin
      state_d = IDLE;
      step    = 1'b0;
      wc_inc  = 1'b0;
      cap_rd  = 1'b0;
      cap_wr  = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      addr        <= '0;
      cnt         <= '0;
      wc          <= '0;
      rd_data     <= '0;
      sram_dq_out <= '0;
      err         <= 1'b0;
    end else begin
      if (load) begin
        addr <= base;
        cnt  <= length;
      end else if (step) begin
        addr <= addr + ADDR_W'(1);
        cnt  <= cnt - ADDR_W'(1);
      end
      wc  <= wc_inc ? wc + WC_W'(1) : '0;
      err <= err_set;
      if (cap_rd) rd_data     <= sram_dq_in;
      if (cap_wr) sram_dq_out <= wr_data;
    end
  end

endmodule
